// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared rggen status codes and APB master state encoding
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_APB_IDLE     = 2'b00,
    RGGEN_APB_SETUP    = 2'b01,
    RGGEN_APB_ACCESS   = 2'b10,
    RGGEN_APB_RESPONSE = 2'b11
  } rggen_apb_master_state;

  // Counter widths must stay at least one bit even for limits of 0 or 1.
  function automatic int rggen_clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rggen_timeout_counter.sv
// rtl/rggen_timeout_counter.sv - wait-state counter that flags when a limit is reached
module rggen_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Expiry fires in the cycle whose increment would reach LIMIT, so the
  // owner can leave on the same edge the count hits the limit.
  assign expired = enable && (LIMIT != 0) && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expired ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/rggen_apb_bridge_master.sv
// rtl/rggen_apb_bridge_master.sv - valid/ready command channel to APB initiator
module rggen_apb_bridge_master
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
  input  logic [DATA_WIDTH-1:0]     i_cmd_write_data,
  input  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]                o_rsp_status,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic                      i_pslverr,
  input  logic [DATA_WIDTH-1:0]     i_prdata
);

  localparam int STROBE_WIDTH  = DATA_WIDTH / 8;
  localparam int BYTE_LSB      = $clog2(STROBE_WIDTH);
  localparam int TIMEOUT_WIDTH = rggen_clog2_min1(TIMEOUT_CYCLES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    ~ADDRESS_WIDTH'((1 << BYTE_LSB) - 1);

  rggen_apb_master_state state;
  rggen_status           rsp_status;

  logic in_access;
  logic timeout_clear;
  logic timeout_enable;
  logic timeout_expired;

  assign in_access      = (state == RGGEN_APB_ACCESS);
  assign timeout_clear  = !in_access || i_pready;
  assign timeout_enable = in_access && !i_pready;
  assign o_rsp_status   = rsp_status;

  rggen_timeout_counter #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timeout_clear),
    .enable  (timeout_enable),
    .expired (timeout_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RGGEN_APB_IDLE;
      o_cmd_ready     <= 1'b1;
      o_rsp_valid     <= 1'b0;
      o_psel          <= 1'b0;
      o_penable       <= 1'b0;
      o_pwrite        <= 1'b0;
      o_paddr         <= '0;
      o_pwdata        <= '0;
      o_pstrb         <= '0;
      o_rsp_read_data <= '0;
      rsp_status      <= RGGEN_OKAY;
    end else begin
      case (state)
        RGGEN_APB_IDLE: begin
          if (i_cmd_valid) begin
            state       <= RGGEN_APB_SETUP;
            o_cmd_ready <= 1'b0;
            o_psel      <= 1'b1;
            o_penable   <= 1'b0;
            o_pwrite    <= i_cmd_write;
            o_paddr     <= i_cmd_address & ALIGN_MASK;
            o_pwdata    <= i_cmd_write ? i_cmd_write_data : '0;
            o_pstrb     <= i_cmd_write ? i_cmd_strobe : '0;
          end
        end
        RGGEN_APB_SETUP: begin
          state     <= RGGEN_APB_ACCESS;
          o_penable <= 1'b1;
        end
        RGGEN_APB_ACCESS: begin
          // A slave completing in the limit cycle takes priority over the timeout.
          if (i_pready) begin
            state           <= RGGEN_APB_RESPONSE;
            o_psel          <= 1'b0;
            o_penable       <= 1'b0;
            o_rsp_valid     <= 1'b1;
            rsp_status      <= i_pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            o_rsp_read_data <= o_pwrite ? '0 : i_prdata;
          end else if (timeout_expired) begin
            state           <= RGGEN_APB_RESPONSE;
            o_psel          <= 1'b0;
            o_penable       <= 1'b0;
            o_rsp_valid     <= 1'b1;
            rsp_status      <= RGGEN_SLAVE_ERROR;
            o_rsp_read_data <= '0;
          end
        end
        RGGEN_APB_RESPONSE: begin
          if (i_rsp_ready) begin
            state       <= RGGEN_APB_IDLE;
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= RGGEN_APB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge_master.sv
// tb/tb_rggen_apb_bridge_master.sv - directed bench for rggen_apb_bridge_master
module tb_rggen_apb_bridge_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [7:0]  i_cmd_address;
  logic [31:0] i_cmd_write_data;
  logic [3:0]  i_cmd_strobe;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_read_data;
  logic [1:0]  o_rsp_status;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [7:0]  o_paddr;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready;
  logic        i_pslverr;
  logic [31:0] i_prdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rggen_apb_bridge_master #(
    .ADDRESS_WIDTH  (8),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_write      (i_cmd_write),
    .i_cmd_address    (i_cmd_address),
    .i_cmd_write_data (i_cmd_write_data),
    .i_cmd_strobe     (i_cmd_strobe),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (i_rsp_ready),
    .o_rsp_read_data  (o_rsp_read_data),
    .o_rsp_status     (o_rsp_status),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_paddr          (o_paddr),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_pslverr        (i_pslverr),
    .i_prdata         (i_prdata)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;      // ACCESS cycles with pready=0 before pready=1; 99 = never
    logic        slverr;
    logic [31:0] prdata;
    logic [7:0]  exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_pwdata;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
    int          exp_cycles; // ACCESS cycles until the response appears
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    i_cmd_valid      = 1'b1;
    i_cmd_write      = wr;
    i_cmd_address    = addr;
    i_cmd_write_data = data;
    i_cmd_strobe     = strb;
  endtask

  task automatic do_xfer(input int idx, input vec_t v);
    int acc;
    bit done;
    check($sformatf("v%0d idle cmd_ready", idx), o_cmd_ready, 1'b1);
    issue_cmd(v.write, v.addr, v.wdata, v.strb);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check($sformatf("v%0d setup psel/penable", idx), {o_psel, o_penable}, 2'b10);
    check($sformatf("v%0d setup pwrite", idx), o_pwrite, v.write);
    check($sformatf("v%0d setup paddr", idx), o_paddr, v.exp_paddr);
    check($sformatf("v%0d setup pstrb", idx), o_pstrb, v.exp_pstrb);
    check($sformatf("v%0d setup pwdata", idx), o_pwdata, v.exp_pwdata);
    check($sformatf("v%0d setup rsp/cmd", idx), {o_rsp_valid, o_cmd_ready}, 2'b00);
    @(negedge clk);
    acc  = 0;
    done = 1'b0;
    while (!done && acc < 12) begin
      check($sformatf("v%0d access%0d ctl", idx, acc), {o_psel, o_penable, o_rsp_valid}, 3'b110);
      check($sformatf("v%0d access%0d stable", idx, acc),
            {o_pwrite, o_paddr, o_pstrb, o_pwdata},
            {v.write, v.exp_paddr, v.exp_pstrb, v.exp_pwdata});
      if (acc == v.waits) begin
        i_pready  = 1'b1;
        i_pslverr = v.slverr;
        i_prdata  = v.prdata;
      end else begin
        i_pready  = 1'b0;
        i_pslverr = 1'b1;
        i_prdata  = 32'hbad0_bad0;
      end
      @(negedge clk);
      acc++;
      done = o_rsp_valid;
    end
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = '0;
    check($sformatf("v%0d access cycles", idx), acc, v.exp_cycles);
    check($sformatf("v%0d rsp ctl", idx), {o_psel, o_penable, o_rsp_valid, o_cmd_ready}, 4'b0010);
    check($sformatf("v%0d rsp status", idx), o_rsp_status, v.exp_status);
    check($sformatf("v%0d rsp rdata", idx), o_rsp_read_data, v.exp_rdata);
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check($sformatf("v%0d back to idle", idx), {o_rsp_valid, o_cmd_ready, o_psel}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //           wr    addr   wdata          strb  waits slv   prdata         paddr  pstrb pwdata         status rdata          cyc
    vecs[0] = '{1'b1, 8'h04, 32'hdeadbeef, 4'hf, 0,  1'b0, 32'h0,        8'h04, 4'hf, 32'hdeadbeef, 2'b00, 32'h0,        1};
    vecs[1] = '{1'b0, 8'h0e, 32'h99999999, 4'hf, 3,  1'b0, 32'h12345678, 8'h0c, 4'h0, 32'h0,        2'b00, 32'h12345678, 4};
    vecs[2] = '{1'b0, 8'h13, 32'h0,        4'h0, 1,  1'b1, 32'hcafef00d, 8'h10, 4'h0, 32'h0,        2'b10, 32'hcafef00d, 2};
    vecs[3] = '{1'b0, 8'h20, 32'h0,        4'h0, 99, 1'b0, 32'h0,        8'h20, 4'h0, 32'h0,        2'b10, 32'h0,        4};
    vecs[4] = '{1'b1, 8'h0b, 32'ha5a5a5a5, 4'h6, 2,  1'b1, 32'hffffffff, 8'h08, 4'h6, 32'ha5a5a5a5, 2'b10, 32'h0,        3};
    vecs[5] = '{1'b1, 8'hff, 32'h01020304, 4'h1, 99, 1'b0, 32'h0,        8'hfc, 4'h1, 32'h01020304, 2'b10, 32'h0,        4};

    rst_n = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_address = '0;
    i_cmd_write_data = '0; i_cmd_strobe = '0; i_rsp_ready = 1'b0;
    i_pready = 1'b0; i_pslverr = 1'b0; i_prdata = '0;
    repeat (3) @(negedge clk);
    check("reset ctl", {o_cmd_ready, o_rsp_valid, o_psel, o_penable, o_pwrite}, 5'b10000);
    check("reset data", {o_paddr, o_pwdata, o_pstrb, o_rsp_read_data, o_rsp_status}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_xfer(i, vecs[i]);

    // Response backpressure with a new command already waiting
    issue_cmd(1'b0, 8'h31, 32'h0, 4'h0);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    i_pready = 1'b1; i_prdata = 32'h11223344;
    @(negedge clk);
    i_pready = 1'b0; i_prdata = '0;
    issue_cmd(1'b1, 8'h40, 32'h55aa55aa, 4'hf);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d ctl", k), {o_cmd_ready, o_psel, o_rsp_valid}, 3'b001);
      check($sformatf("bp%0d rsp", k), {o_rsp_status, o_rsp_read_data}, {2'b00, 32'h11223344});
      @(negedge clk);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("bp release", {o_cmd_ready, o_rsp_valid, o_psel}, 3'b100);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("bp next setup", {o_psel, o_penable, o_paddr, o_pwdata}, {2'b10, 8'h40, 32'h55aa55aa});
    @(negedge clk);
    i_pready = 1'b1;
    @(negedge clk);
    i_pready = 1'b0;
    check("bp next rsp", {o_rsp_valid, o_rsp_status, o_rsp_read_data}, {1'b1, 2'b00, 32'h0});
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;

    // Reset during an ACCESS wait state, then a full 3-wait read
    issue_cmd(1'b0, 8'h50, 32'h0, 4'h0);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset access", {o_psel, o_penable}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset", {o_psel, o_penable, o_rsp_valid, o_cmd_ready}, 4'b0001);
    do_xfer(6, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
